// File: rtl/defines.sv
// Shared types for the I/O request path between cores and the device register bus.
package defines;

  localparam int CORE_COUNT       = 4;
  localparam int THREADS_PER_CORE = 4;

  typedef logic [$clog2(CORE_COUNT)-1:0]       core_id_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;

  typedef struct packed {
    logic              store;
    logic [31:0]       address;
    logic [31:0]       value;
    local_thread_idx_t thread_idx;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t          core;
    local_thread_idx_t thread_idx;
    logic [31:0]       read_value;
  } iorsp_packet_t;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_ISSUE,
    IO_WAIT,
    IO_RESPOND
  } io_responder_state_t;

endpackage

// File: rtl/oh_to_idx.sv
// Converts a one-hot vector to its binary index.
module oh_to_idx #(
  parameter int NUM_SIGNALS = 4,
  parameter int INDEX_WIDTH = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
  input  logic [NUM_SIGNALS-1:0] one_hot,
  output logic [INDEX_WIDTH-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (|(one_hot & (NUM_SIGNALS'(1) << i))) index = index | INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the most recent grant has highest priority.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  logic [NUM_REQUESTERS-1:0] last_q;
  logic [NUM_REQUESTERS-1:0] above_last;
  logic [NUM_REQUESTERS-1:0] masked;

  // Bits strictly above the last winner; empty when the last winner was the top requester.
  always_comb begin
    above_last = ~((last_q << 1) - NUM_REQUESTERS'(1));
    masked     = request & above_last;
    if (|masked) grant_oh = masked & (~masked + NUM_REQUESTERS'(1));
    else         grant_oh = request & (~request + NUM_REQUESTERS'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= {1'b1, {(NUM_REQUESTERS-1){1'b0}}};
    else if (update_lru && |request) last_q <= grant_oh;
  end

endmodule

// File: rtl/io_request_responder.sv
// Target-side I/O request endpoint: arbitrates among cores, runs one bus transaction
// at a time, and broadcasts a completion to wake the requesting thread.
module io_request_responder
  import defines::*;
#(
  parameter int NUM_CORES      = CORE_COUNT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] ior_request_valid,
  input  ioreq_packet_t        ior_request [NUM_CORES],
  output logic [NUM_CORES-1:0] ii_ready,
  output logic                 ii_response_valid,
  output iorsp_packet_t        ii_response,
  output logic                 io_read_en,
  output logic                 io_write_en,
  output logic [31:0]          io_address,
  output logic [31:0]          io_write_data,
  input  logic [31:0]          io_read_data,
  input  logic                 io_ready,
  output logic                 io_timeout
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  io_responder_state_t state_q, state_d;
  logic                store_q, store_d;
  logic [31:0]         address_q, address_d;
  logic [31:0]         wdata_q, wdata_d;
  local_thread_idx_t   thread_q, thread_d;
  logic [IDX_W-1:0]    core_q, core_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_CORES-1:0] grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 update_lru;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_CORES)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (ior_request_valid),
    .update_lru(update_lru),
    .grant_oh  (grant_oh)
  );

  oh_to_idx #(
    .NUM_SIGNALS(NUM_CORES),
    .INDEX_WIDTH(IDX_W)
  ) u_grant_idx (
    .one_hot(grant_oh),
    .index  (grant_idx)
  );

  always_comb begin
    state_d           = state_q;
    store_d           = store_q;
    address_d         = address_q;
    wdata_d           = wdata_q;
    thread_d          = thread_q;
    core_d            = core_q;
    rdata_d           = rdata_q;
    cnt_d             = cnt_q;
    ii_ready          = '0;
    update_lru        = 1'b0;
    io_read_en        = 1'b0;
    io_write_en       = 1'b0;
    io_timeout        = 1'b0;
    ii_response_valid = 1'b0;
    ii_response       = '0;
    case (state_q)
      IO_IDLE: begin
        ii_ready = grant_oh;
        if (|ior_request_valid) begin
          update_lru = 1'b1;
          store_d    = ior_request[grant_idx].store;
          address_d  = ior_request[grant_idx].address;
          wdata_d    = ior_request[grant_idx].value;
          thread_d   = ior_request[grant_idx].thread_idx;
          core_d     = grant_idx;
          state_d    = IO_ISSUE;
        end
      end
      IO_ISSUE: begin
        io_write_en = store_q;
        io_read_en  = !store_q;
        cnt_d       = '0;
        state_d     = IO_WAIT;
      end
      // An acknowledge arriving in the timeout cycle takes precedence over the timeout.
      IO_WAIT: begin
        if (io_ready) begin
          rdata_d = store_q ? 32'h0 : io_read_data;
          state_d = IO_RESPOND;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d    = 32'hFFFF_FFFF;
          io_timeout = 1'b1;
          state_d    = IO_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IO_RESPOND: begin
        ii_response_valid      = 1'b1;
        ii_response.core       = core_id_t'(core_q);
        ii_response.thread_idx = thread_q;
        ii_response.read_value = rdata_q;
        state_d                = IO_IDLE;
      end
      default: state_d = IO_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IO_IDLE;
      store_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      thread_q  <= '0;
      core_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      thread_q  <= thread_d;
      core_q    <= core_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign io_address    = address_q;
  assign io_write_data = wdata_q;

endmodule

// File: tb/tb_io_request_responder.sv
// Directed bench for io_request_responder: reads, stores, round-robin fairness,
// timeout handling and reset mid-transaction.
module tb_io_request_responder;
  import defines::*;

  localparam int NCORES = 4;
  localparam int TMO    = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCORES-1:0]   ior_request_valid;
  ioreq_packet_t       ior_request [NCORES];
  logic [NCORES-1:0]   ii_ready;
  logic                ii_response_valid;
  iorsp_packet_t       ii_response;
  logic                io_read_en;
  logic                io_write_en;
  logic [31:0]         io_address;
  logic [31:0]         io_write_data;
  logic [31:0]         io_read_data;
  logic                io_ready;
  logic                io_timeout;

  int nAsserts = 0;
  int nFails   = 0;
  int tmoAt;
  int waitLen;

  io_request_responder #(
    .NUM_CORES     (NCORES),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ior_request_valid(ior_request_valid),
    .ior_request      (ior_request),
    .ii_ready         (ii_ready),
    .ii_response_valid(ii_response_valid),
    .ii_response      (ii_response),
    .io_read_en       (io_read_en),
    .io_write_en      (io_write_en),
    .io_address       (io_address),
    .io_write_data    (io_write_data),
    .io_read_data     (io_read_data),
    .io_ready         (io_ready),
    .io_timeout       (io_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NCORES-1:0] valid, input logic rdy, input logic [31:0] rdata);
    ior_request_valid = valid;
    io_ready          = rdy;
    io_read_data      = rdata;
    #1;
  endtask

  task automatic setRequest(input logic [1:0] core, input logic st, input logic [31:0] addr,
                            input logic [31:0] val, input logic [1:0] thr);
    ior_request[core] = '{store: st, address: addr, value: val, thread_idx: local_thread_idx_t'(thr)};
  endtask

  function automatic iorsp_packet_t mkRsp(input logic [1:0] c, input logic [1:0] t, input logic [31:0] v);
    iorsp_packet_t r;
    r.core       = core_id_t'(c);
    r.thread_idx = local_thread_idx_t'(t);
    r.read_value = v;
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    for (int c = 0; c < NCORES; c++) ior_request[c] = '0;
    applyStimulus('0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_ready", 64'(ii_ready), 64'h0);
    checkOutput("rst_rsp_valid", 64'(ii_response_valid), 64'h0);
    checkOutput("rst_rsp", 64'(ii_response), 64'h0);
    checkOutput("rst_strobes", 64'({io_read_en, io_write_en, io_timeout}), 64'h0);
    checkOutput("rst_addr_data", {io_address, io_write_data}, 64'h0);
    reset = 1'b0;
    tick();

    // Single read from core 1 thread 2, acknowledged in the first wait cycle
    setRequest(2'd1, 1'b0, 32'h100, 32'h0, 2'd2);
    applyStimulus(4'b0010, 1'b0, 32'h0);
    checkOutput("t1_ready", 64'(ii_ready), 64'h2);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t1_read_en", 64'(io_read_en), 64'h1);
    checkOutput("t1_write_en", 64'(io_write_en), 64'h0);
    checkOutput("t1_addr", 64'(io_address), 64'h100);
    tick();
    applyStimulus('0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("t1_wait_noresp", 64'(ii_response_valid), 64'h0);
    checkOutput("t1_wait_nostrobe", 64'(io_read_en), 64'h0);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t1_rsp_valid", 64'(ii_response_valid), 64'h1);
    checkOutput("t1_rsp", 64'(ii_response), 64'(mkRsp(2'd1, 2'd2, 32'hDEAD_BEEF)));
    tick();
    checkOutput("t1_idle_valid", 64'(ii_response_valid), 64'h0);

    // Store from core 0: response carries zero regardless of bus read data
    setRequest(2'd0, 1'b1, 32'h20, 32'h55, 2'd1);
    applyStimulus(4'b0001, 1'b0, 32'h0);
    checkOutput("t2_ready", 64'(ii_ready), 64'h1);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t2_write_en", 64'(io_write_en), 64'h1);
    checkOutput("t2_read_en", 64'(io_read_en), 64'h0);
    checkOutput("t2_addr", 64'(io_address), 64'h20);
    checkOutput("t2_wdata", 64'(io_write_data), 64'h55);
    tick();
    applyStimulus('0, 1'b1, 32'h1234_5678);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t2_rsp_valid", 64'(ii_response_valid), 64'h1);
    checkOutput("t2_rsp", 64'(ii_response), 64'(mkRsp(2'd0, 2'd1, 32'h0)));
    tick();

    // All cores request continuously after reset: grants rotate 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < NCORES; c++) setRequest(2'(c), 1'b0, 32'h1000 + 32'(c * 4), 32'h0, 2'(c));
    applyStimulus(4'hF, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t3_grant", 64'(ii_ready), 64'(4'(1) << (k % 4)));
      tick();
      applyStimulus(4'hF, 1'b0, 32'h0);
      checkOutput("t3_issue_ready", 64'(ii_ready), 64'h0);
      checkOutput("t3_issue_addr", 64'(io_address), 64'(32'h1000 + 32'((k % 4) * 4)));
      tick();
      applyStimulus(4'hF, 1'b1, 32'hA0 + 32'(k));
      checkOutput("t3_wait_ready", 64'(ii_ready), 64'h0);
      tick();
      applyStimulus(4'hF, 1'b0, 32'h0);
      checkOutput("t3_rsp_ready", 64'(ii_ready), 64'h0);
      checkOutput("t3_rsp", {31'h0, ii_response_valid, 28'h0, ii_response},
                  {31'h0, 1'b1, 28'h0, mkRsp(2'(k % 4), 2'(k % 4), 32'hA0 + 32'(k))});
      tick();
    end
    applyStimulus('0, 1'b0, 32'h0);
    tick();

    // Peripheral never acknowledges: expect timeout, all-ones value, return to idle
    setRequest(2'd2, 1'b0, 32'h300, 32'h0, 2'd3);
    applyStimulus(4'b0100, 1'b0, 32'h0);
    checkOutput("t4_ready", 64'(ii_ready), 64'h4);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t4_read_en", 64'(io_read_en), 64'h1);
    tmoAt = -1;
    for (int c = 1; c <= TMO + 6 && tmoAt < 0; c++) begin
      tick();
      if (io_timeout) tmoAt = c;
    end
    checkOutput("t4_tmo_window", 64'(tmoAt >= TMO && tmoAt <= TMO + 2), 64'h1);
    checkOutput("t4_tmo_noresp", 64'(ii_response_valid), 64'h0);
    tick();
    checkOutput("t4_rsp_valid", 64'(ii_response_valid), 64'h1);
    checkOutput("t4_rsp", 64'(ii_response), 64'(mkRsp(2'd2, 2'd3, 32'hFFFF_FFFF)));
    checkOutput("t4_tmo_pulse_end", 64'(io_timeout), 64'h0);
    tick();
    applyStimulus('0, 1'b1, 32'h0000_0BAD);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t4_late_ack", 64'({ii_response_valid, io_timeout, io_read_en, io_write_en}), 64'h0);
      tick();
    end
    applyStimulus('0, 1'b0, 32'h0);

    // Acknowledge in the very cycle the timeout would fire: data wins
    waitLen = (tmoAt > 0) ? tmoAt : TMO + 1;
    setRequest(2'd2, 1'b0, 32'h304, 32'h0, 2'd1);
    applyStimulus(4'b0100, 1'b0, 32'h0);
    checkOutput("t4b_ready", 64'(ii_ready), 64'h4);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    for (int c = 1; c < waitLen; c++) tick();
    tick();
    applyStimulus('0, 1'b1, 32'h600D_F00D);
    checkOutput("t4b_no_tmo", 64'(io_timeout), 64'h0);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t4b_rsp", {31'h0, ii_response_valid, 28'h0, ii_response},
                {31'h0, 1'b1, 28'h0, mkRsp(2'd2, 2'd1, 32'h600D_F00D)});
    tick();

    // Reset during WAIT drops the transaction; a later request completes normally
    setRequest(2'd3, 1'b1, 32'h40, 32'h77, 2'd0);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    checkOutput("t5_ready", 64'(ii_ready), 64'h8);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t5_write", {31'h0, io_write_en, io_write_data}, {31'h0, 1'b1, 32'h77});
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_ctrl", 64'({ii_ready, ii_response_valid, io_read_en, io_write_en, io_timeout}), 64'h0);
    checkOutput("t5_rst_rsp", 64'(ii_response), 64'h0);
    checkOutput("t5_rst_bus", {io_address, io_write_data}, 64'h0);
    reset = 1'b0;
    applyStimulus('0, 1'b1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t5_no_rsp", 64'(ii_response_valid), 64'h0);
    end
    setRequest(2'd3, 1'b0, 32'h44, 32'h0, 2'd2);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    checkOutput("t5b_ready", 64'(ii_ready), 64'h8);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t5b_read", {31'h0, io_read_en, io_address}, {31'h0, 1'b1, 32'h44});
    tick();
    applyStimulus('0, 1'b1, 32'hCAFE_F00D);
    tick();
    applyStimulus('0, 1'b0, 32'h0);
    checkOutput("t5b_rsp", {31'h0, ii_response_valid, 28'h0, ii_response},
                {31'h0, 1'b1, 28'h0, mkRsp(2'd3, 2'd2, 32'hCAFE_F00D)});
    tick();
    checkOutput("t5b_idle", 64'(ii_response_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
